// File: rtl/sha256_pkg.sv
// Shared types and widths for the SHA-256 miner control blocks.
package sha256_pkg;

    localparam int unsigned ROUND_W      = 6;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned ROUNDS_MAX   = 64;
    // First round whose W word comes from the message-schedule expansion.
    localparam int unsigned SCHED_SWITCH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/k_table.sv
// SHA-256 round constant ROM: round index in, K[round] out (combinational).
module k_table
    import sha256_pkg::*;
(
    input  logic [ROUND_W-1:0] addr,
    output logic [WORD_W-1:0]  k_c
);

    localparam logic [WORD_W-1:0] K_ROM [ROUNDS_MAX] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ROM read
    assign k_c = K_ROM[addr];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for one SHA-256 compression: framing pulses, round counter and
// a registered round constant aligned with the per-round enable.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic              abort,
    input  logic              stall,
    output logic [5:0]        round,
    output logic [31:0]       k_out,
    output logic              w_sel,
    output logic              load_iv,
    output logic              round_en,
    output logic              final_add,
    output logic              done
);

    localparam logic [ROUND_W-1:0] LAST_ROUND   = ROUND_W'(ROUNDS - 1);
    localparam logic [ROUND_W-1:0] SWITCH_ROUND = ROUND_W'(SCHED_SWITCH);

    state_e              state_q, state_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [WORD_W-1:0]   k_q, k_d, k_rom;
    logic                ready_q, ready_d;
    logic                load_iv_q, load_iv_d;
    logic                round_en_q, round_en_d;
    logic                final_add_q, final_add_d;
    logic                done_q, done_d;

    // Constant lookup is addressed with the next round so k_out lands with round.
    k_table u_k_table (
        .addr (round_d),
        .k_c  (k_rom)
    );

    // Next-state, next-round and next-output decode. round_en_q marks a cycle
    // whose round retires at the closing edge; stall sampled at an edge in
    // ROUND turns the following cycle into a bubble.
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        round_en_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                round_d = '0;
                if (start && !abort) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                round_d    = '0;
                state_d    = ST_ROUND;
                round_en_d = 1'b1;
            end
            ST_ROUND: begin
                if (round_en_q) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_FINAL;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                    end
                end
                if (state_d == ST_ROUND) begin
                    round_en_d = !stall;
                end
            end
            ST_FINAL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                round_d = '0;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            round_d    = '0;
            round_en_d = 1'b0;
        end

        ready_d     = (state_d == ST_IDLE);
        load_iv_d   = (state_d == ST_LOAD);
        final_add_d = (state_d == ST_FINAL);
        done_d      = (state_d == ST_DONE);
        k_d         = ((state_d == ST_LOAD) || (state_d == ST_ROUND)) ? k_rom : '0;
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            k_q         <= '0;
            ready_q     <= 1'b1;
            load_iv_q   <= 1'b0;
            round_en_q  <= 1'b0;
            final_add_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            k_q         <= k_d;
            ready_q     <= ready_d;
            load_iv_q   <= load_iv_d;
            round_en_q  <= round_en_d;
            final_add_q <= final_add_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign round     = round_q;
    assign k_out     = k_q;
    assign w_sel     = (round_q >= SWITCH_ROUND);
    assign load_iv   = load_iv_q;
    assign round_en  = round_en_q;
    assign final_add = final_add_q;
    assign done      = done_q;

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencer for one SHA-256 compression in the miner datapath. It accepts a start request and steps a 6-bit round counter through the compression rounds. It drives the `k_table` constant lookup and presents a registered round constant aligned with per-round enables for the compression datapath. It also emits the load-IV, final-add and done pulses that frame each compression.

## Interface
- `ROUNDS`, default 64: number of rounds per compression. Legal range 1..64. Values below 64 are for test only.
- `clk`  in  1  — single clock for the block.
- `rst`  in  1  — reset; asynchronous, active-high.
- `start`  in  1  — compression request. Accepted only when `ready`=1.
- `ready`  out  1  — high in IDLE only.
- `abort`  in  1  — synchronous cancel of the compression in progress.
- `stall`  in  1  — datapath/message-schedule backpressure. Honoured only in ROUND.
- `round`  out  6  — current round index, registered.
- `k_out`  out  32  — round constant for `round`, registered.
- `w_sel`  out  1  — 0: W comes from block word `round` (round<16). 1: W comes from schedule expansion.
- `load_iv`  out  1  — one-cycle pulse: datapath loads a..h from the hash state.
- `round_en`  out  1  — datapath executes one round this cycle using `k_out`.
- `final_add`  out  1  — one-cycle pulse: datapath adds a..h into the hash state.
- `done`  out  1  — one-cycle pulse: compression complete.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE: `ready`=1.
  - `start`=1 and `abort`=0 → LOAD.
  - `start` with `abort` in the same cycle: remain IDLE.
- LOAD: `load_iv`=1, `round`=0, `k_out`=K[0]. Unconditionally → ROUND, unless `abort`.
- ROUND:
  - `stall`=0: `round_en`=1. If `round`=ROUNDS-1 → FINAL; else `round`+1, and `k_out` updates to K[`round`+1] on the same edge.
  - `stall`=1: `round_en`=0; `round` and `k_out` hold.
- FINAL: `final_add`=1 → DONE.
- DONE: `done`=1 → IDLE. `round` returns to 0.
- `abort` in any non-IDLE state → IDLE next cycle. No `final_add`, no `done`. `round` is cleared to 0. `abort` has priority over `stall` and over normal transitions.
- `start` outside IDLE is ignored; it is not queued.
- `k_out` is driven by a register fed from `k_table` addressed with the next-round value, so `k_out` always equals K[`round`] in LOAD and ROUND.
- `w_sel` = (`round` >= 16), decoded from the `round` register.
- Round counter: 6-bit, never wraps. The terminal compare is against ROUNDS-1.

## Timing
- Reset values:
  - state IDLE, so `ready`=1;
  - `round`=0, `k_out`=32'h0, `w_sel`=0;
  - `load_iv`, `round_en`, `final_add` and `done` all 0.
- Cycle 0 is the `start` accept edge. Without stalls:
  - LOAD in cycle 1;
  - ROUND in cycles 2..ROUNDS+1;
  - FINAL in cycle ROUNDS+2;
  - DONE in cycle ROUNDS+3;
  - `ready` again in cycle ROUNDS+4.
- For ROUNDS=64: `done` 67 cycles after accept. Each stalled cycle adds 1.
- Minimum start-to-start interval is ROUNDS+4 cycles.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Async reset mid-compression: all outputs take reset values immediately. The first accept after reset release follows the normal sequence.

## Structure
- Shared package `sha256_pkg`:
  - FSM state encoding;
  - `ROUND_W`=6, `WORD_W`=32;
  - `ROUNDS_MAX`=64;
  - `SCHED_SWITCH`=16, the `w_sel` threshold.
- One sub-module: the existing `k_table` (6-bit round in, 32-bit constant out), instantiated once. Its output is registered in this block.
- Everything else is the FSM plus counter, inline.

## Test plan
- Reset, then `start` pulse with ROUNDS=64 → `load_iv` at cycle 1. Check `k_out`:
  - 32'h428a2f98 at round 0 (cycle 2);
  - 32'h0fc19dc6 at round 18;
  - 32'hc67178f2 at round 63 (cycle 65).
  - Also check `final_add` at 66, `done` at 67, and exactly 64 `round_en` cycles.
- `stall` high for 3 cycles while `round`=20 → `round` and `k_out` (32'h2de92c6f) hold, and `round_en`=0 for those cycles. `done` arrives at cycle 70.
- `abort` while `round`=30 → IDLE next cycle: `ready`=1, `round`=0, and no `final_add`/`done` ever. A following `start` runs a full clean compression.
- `start` asserted continuously from cycle 0 → exactly one compression per ROUNDS+4 cycles. `start` during busy cycles is never accepted.
- `rst` asserted at `round`=40 → outputs take reset values asynchronously. A following `start` shows `k_out`=32'h428a2f98 at round 0.
- ROUNDS=4 → `round_en` for rounds 0..3 with K values 428a2f98, 71374491, b5c0fbcf, e9b5dba5. `w_sel` stays 0. `done` at cycle 7.
